// File: rtl/sipo_pkg.sv
// Shared types and helpers for the sipo_deser serial-to-parallel deserialiser.
// Holds the holding-register state encoding and the bit-counter width function.
package sipo_pkg;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_t;

    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// Serial-input and parallel-output bundle of sipo_deser.
// master = line receiver/consumer side, slave = deserialiser.
interface sipo_deser_if
    import sipo_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int CW = cnt_width(WIDTH);

    logic             sin;
    logic             sin_valid;
    logic             clear;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic             pout_ready;
    logic [CW-1:0]    bit_cnt;
    logic             overflow;

    modport master (
        output sin, sin_valid, clear, pout_ready,
        input  pout, pout_valid, bit_cnt, overflow
    );

    modport slave (
        input  sin, sin_valid, clear, pout_ready,
        output pout, pout_valid, bit_cnt, overflow
    );

endinterface

// File: rtl/sipo_shift_core.sv
// Shift register plus wrapping bit counter for sipo_deser.
// word/word_done expose the post-shift value on the edge that completes a word.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1,
    localparam int CW       = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] word,
    output logic             word_done,
    output logic [CW-1:0]    bit_cnt
);

    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_next;
    logic             last_bit;

    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign sh_next = {sin, sh[WIDTH-1:1]};
        end else begin : g_msb_first
            assign sh_next = {sh[WIDTH-2:0], sin};
        end
    endgenerate

    assign last_bit  = (bit_cnt == CW'(WIDTH - 1));
    // clear wins over a simultaneous bit, so that bit can never complete a word
    assign word_done = sin_valid && !clear && last_bit;
    assign word      = sh_next;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sh      <= '0;
            bit_cnt <= '0;
        end else if (sin_valid) begin
            sh      <= sh_next;
            bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Parametrised serial-in/parallel-out deserialiser with a one-word holding register.
// Completed words are offered on pout with valid/ready; a word arriving while full and stalled is dropped.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    sipo_deser_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] word;
    logic             word_done;
    logic [CW-1:0]    bit_cnt;

    hold_state_t      state;
    hold_state_t      state_next;
    logic             load;
    logic             ovf_set;
    logic [WIDTH-1:0] pout_q;
    logic             overflow_q;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .sin       (bus.sin),
        .sin_valid (bus.sin_valid),
        .clear     (bus.clear),
        .word      (word),
        .word_done (word_done),
        .bit_cnt   (bit_cnt)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        ovf_set    = 1'b0;
        case (state)
            HOLD_EMPTY: begin
                if (word_done) begin
                    load       = 1'b1;
                    state_next = HOLD_FULL;
                end
            end
            HOLD_FULL: begin
                if (bus.pout_ready) begin
                    // consume and refill on the same edge to avoid a bubble
                    if (word_done) begin
                        load = 1'b1;
                    end else begin
                        state_next = HOLD_EMPTY;
                    end
                end else if (word_done) begin
                    ovf_set = 1'b1;
                end
            end
            default: state_next = HOLD_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HOLD_EMPTY;
            pout_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                pout_q <= word;
            end
            if (bus.clear) begin
                overflow_q <= 1'b0;
            end else if (ovf_set) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.pout       = pout_q;
    assign bus.pout_valid = (state == HOLD_FULL);
    assign bus.bit_cnt    = bit_cnt;
    assign bus.overflow   = overflow_q;

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Parametrised serial-in/parallel-out deserialiser; next generation of the 4-bit SIPO.
- Collects WIDTH serial bits gated by a valid strobe and counts bits internally, so no external mode toggling is needed.
- Presents each completed word on a parallel port with a valid/ready handshake and a one-word holding register, so shifting continues while the consumer stalls.
- Sits between a serial line receiver and a word-wide consumer.

Parameters:
- WIDTH, 8, parallel word width in bits; legal range is WIDTH >= 2.
- LSB_FIRST, 1, 1 = first received bit lands in pout[0]; 0 = first received bit lands in pout[WIDTH-1].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is sampled on a rising clk edge only when this is high.
- clear  input  1  synchronous abort of the partial word; also clears overflow.
- pout  output  WIDTH  parallel word from the holding register.
- pout_valid  output  1  holding register contains a word.
- pout_ready  input  1  consumer accepts pout when pout_valid && pout_ready.
- bit_cnt  output  $clog2(WIDTH)  number of bits collected in the current partial word.
- overflow  output  1  sticky; set when a completed word is dropped.

Behaviour:
- Reset: rst=1 at a clk edge forces shift register=0, bit_cnt=0, pout=0, pout_valid=0, overflow=0. Reset overrides every other input. Reset mid-word discards the partial word and any held word.
- Shift, LSB_FIRST=1: on sin_valid, sh <= {sin, sh[WIDTH-1:1]}.
- Shift, LSB_FIRST=0: on sin_valid, sh <= {sh[WIDTH-2:0], sin}.
- Counter: bit_cnt increments on each sin_valid and wraps from WIDTH-1 to 0. No shift and no count when sin_valid=0; gaps of any length are allowed.
- Word complete: the edge where sin_valid=1 and bit_cnt==WIDTH-1. The completed word is the post-shift value of sh.
- Holding state machine, two states:
  - HOLD_EMPTY: a completed word loads pout, sets pout_valid, moves to HOLD_FULL.
  - HOLD_FULL, pout_ready=1: the word is consumed this edge. If a word also completes this edge, it loads pout and the state stays HOLD_FULL (back-to-back, no bubble). Otherwise pout_valid clears and the state returns to HOLD_EMPTY.
  - HOLD_FULL, pout_ready=0: a completing word is dropped, overflow <= 1, and pout/pout_valid are unchanged.
- Latency: the word appears on pout with pout_valid=1 in the cycle after the edge that captured its last bit.
- Stability: pout is held constant while pout_valid && !pout_ready.
- clear:
  - Sets sh=0, bit_cnt=0, overflow=0.
  - Takes priority over a simultaneous sin_valid; that bit is discarded and the word does not complete.
  - Does not touch pout/pout_valid; the held word survives.
  - A handshake in the same cycle as clear still completes normally.
- pout_ready while pout_valid=0 has no effect.
- overflow stays high until rst or clear.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package sipo_pkg: holding-state enum HOLD_EMPTY/HOLD_FULL; helper constant function for the counter width, which is $clog2(WIDTH).
- One sub-module, sipo_shift_core: shift register plus bit counter. Parameters WIDTH, LSB_FIRST. Inputs clk, rst, sin, sin_valid, clear. Outputs word, word_done (1-cycle pulse qualified with the post-shift word), bit_cnt.
- The top level holds the holding register, FSM, handshake and overflow logic.

Test Plan:
- WIDTH=4, LSB_FIRST=1, pout_ready=1, sin 1,0,1,1 on consecutive valid cycles -> pout=4'b1101, pout_valid high for exactly 1 cycle, 1 cycle after the 4th bit; bit_cnt 1,2,3,0.
- WIDTH=4, LSB_FIRST=0, same bits with sin_valid toggled off every other cycle -> pout=4'b1011; bit_cnt holds during gaps.
- WIDTH=8, pout_ready=0, send 0xA5 then 0x3C serially (first bit in pout[0]) -> pout stays 0xA5 and valid; overflow=1 on the 0x3C completion edge. Raise pout_ready -> 0xA5 consumed, pout_valid=0, overflow remains 1.
- WIDTH=8, pout_ready=1, 16 continuous valid bits encoding 0x0F then 0xF0 (first bit in pout[0]) -> two valid pulses 8 cycles apart with correct words; no overflow.
- clear after 3 bits, then 4 bits 0,0,0,1 (WIDTH=4, LSB_FIRST=1) -> pout=4'b1000; the pre-clear bits are absent.
- rst asserted with pout_valid=1 and bit_cnt=2 -> next cycle: pout=0, pout_valid=0, bit_cnt=0, overflow=0.
